// File: rtl/lp_pkg.sv
// ============================================================================
//  Module      : lp_pkg
//  Description : Shared widths, entry type and one-hot decode helper for the
//                low-priority-code decode sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lp_pkg;

    localparam int ENTRY_W = 3;   // {none, code[1:0]}
    localparam int CODE_W  = 2;
    localparam int OUT_W   = 4;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Bit index to one-hot; an entry flagged "none" decodes to all zeros.
    function automatic logic [OUT_W-1:0] onehot_dec(input entry_t e);
        logic [OUT_W-1:0] v;
        v = '0;
        if (!e[ENTRY_W-1]) begin
            v[e[CODE_W-1:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage : lp_pkg

`default_nettype wire

// File: rtl/lp_code_fifo.sv
// ============================================================================
//  Module      : lp_code_fifo
//  Description : DEPTH-entry show-ahead FIFO holding {none, code} entries.
//                Caller guarantees push only when not full and pop only
//                when not empty; clear wins over both.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lp_code_fifo
    import lp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  entry_t                   i_wdata,
    input  logic                     i_pop,
    output entry_t                   o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    // Storage needs no reset: only entries covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : lp_code_fifo

`default_nettype wire

// File: rtl/lp_decode_seq.sv
// ============================================================================
//  Module      : lp_decode_seq
//  Description : Queues codes from a low-priority encoder and presents their
//                one-hot decode with valid/ready handshaking. Optional
//                delivered-decode accumulator enabled by LP_DEC_ACCUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lp_decode_seq
    import lp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    in_code,
    input  logic                 in_none,
    output logic                 in_ready,
    output logic [OUT_W-1:0]     y,
    output logic                 y_valid,
    input  logic                 y_ready
`ifdef LP_DEC_ACCUM_EN
    ,
    output logic [OUT_W-1:0]     acc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [CW-1:0]  w_count;
    entry_t         w_head;
    logic           w_push;
    logic           w_pop;
    logic [OUT_W-1:0] w_dec;

    // Handshake qualifiers; a flush suppresses both transfers.
    always_comb begin
        in_ready = (w_count != C_FULL);
        y_valid  = (w_count != '0);
        w_push   = in_valid && in_ready && !clr;
        w_pop    = y_valid && y_ready && !clr;
        w_dec    = onehot_dec(w_head);
        y        = y_valid ? w_dec : '0;
    end

    lp_code_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_push  (w_push),
        .i_wdata ({in_none, in_code}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

`ifdef LP_DEC_ACCUM_EN
    logic [OUT_W-1:0] r_acc;

    // OR in every delivered decode; "none" entries contribute zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (w_pop) begin
            r_acc <= r_acc | y;
        end
    end

    assign acc = r_acc;
`endif

endmodule : lp_decode_seq

`default_nettype wire

// File: tb/tb_lp_decode_seq.sv
// ============================================================================
//  Module      : tb_lp_decode_seq
//  Description : Self-checking bench for lp_decode_seq (DEPTH=4): directed
//                scenarios with literal expectations plus random traffic,
//                all compared every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lp_decode_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_code = 2'd0;
    logic       in_none = 1'b0;
    logic       in_ready;
    logic [3:0] y;
    logic       y_valid;
    logic       y_ready = 1'b0;
`ifdef LP_DEC_ACCUM_EN
    logic [3:0] acc;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    // Reference state: queued entries and accumulated delivered decodes.
    logic [2:0] m_q[$];
    logic [3:0] m_acc = 4'd0;

    lp_decode_seq #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_none  (in_none),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
`ifdef LP_DEC_ACCUM_EN
        ,
        .acc      (acc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_dec(input logic [2:0] e);
        if (e[2]) return 4'd0;
        return 4'(1 << e[1:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (!rst_n || clr) begin
            m_q.delete();
            m_acc = 4'd0;
        end else begin
            do_pop  = (m_q.size() != 0) && y_ready;
            do_push = in_valid && (m_q.size() < DEPTH);
            if (do_pop) begin
                m_acc = m_acc | m_dec(m_q[0]);
                void'(m_q.pop_front());
            end
            if (do_push) m_q.push_back({in_none, in_code});
        end
    endtask

    // Model advances on the same events as the design state.
    always @(posedge clk or negedge rst_n) model_step();

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
            chk("y_valid", 32'(y_valid), 32'(m_q.size() != 0));
            chk("y", 32'(y), 32'((m_q.size() != 0) ? m_dec(m_q[0]) : 4'd0));
`ifdef LP_DEC_ACCUM_EN
            chk("acc", 32'(acc), 32'(m_acc));
`endif
        end
    end

    // Apply inputs now (caller sits just after a falling edge), then let one
    // rising edge pass and return just after the following falling edge.
    task automatic drive(input bit v, input bit [1:0] c, input bit n, input bit r, input bit cl);
        in_valid = v;
        in_code  = c;
        in_none  = n;
        y_ready  = r;
        clr      = cl;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_y_valid", 32'(y_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Decode sweep with continuous consumption.
        drive(1, 2'd0, 0, 1, 0); chk("sweep0", 32'(y), 32'h1);
        drive(1, 2'd1, 0, 1, 0); chk("sweep1", 32'(y), 32'h2);
        drive(1, 2'd2, 0, 1, 0); chk("sweep2", 32'(y), 32'h4);
        drive(1, 2'd3, 0, 1, 0); chk("sweep3", 32'(y), 32'h8);
        drive(0, 2'd0, 0, 1, 0); chk("sweep_empty", 32'(y_valid), 32'd0);
        drive(0, 2'd0, 0, 0, 1);

        // in_none entry decodes to zero and leaves the accumulator alone.
        drive(1, 2'd3, 1, 0, 0);
        chk("none_valid", 32'(y_valid), 32'd1);
        chk("none_y", 32'(y), 32'd0);
        drive(0, 2'd0, 0, 1, 0);
`ifdef LP_DEC_ACCUM_EN
        chk("none_acc", 32'(acc), 32'd0);
`endif

        // Fill under backpressure; fifth push must be dropped.
        drive(1, 2'd3, 0, 0, 0);
        drive(1, 2'd1, 0, 0, 0);
        drive(1, 2'd0, 0, 0, 0);
        drive(1, 2'd2, 0, 0, 0);
        chk("full_ready", 32'(in_ready), 32'd0);
        drive(1, 2'd1, 0, 0, 0);
        chk("full_ready2", 32'(in_ready), 32'd0);
        chk("full_head", 32'(y), 32'h8);
        drive(0, 2'd0, 0, 1, 0); chk("drain1", 32'(y), 32'h2);
        drive(0, 2'd0, 0, 1, 0); chk("drain2", 32'(y), 32'h1);
        drive(0, 2'd0, 0, 1, 0); chk("drain3", 32'(y), 32'h4);
        drive(0, 2'd0, 0, 1, 0); chk("drain_empty", 32'(y_valid), 32'd0);

        // Flush at count=2 with a concurrent push and pop.
        drive(1, 2'd1, 0, 0, 0);
        drive(1, 2'd2, 0, 0, 0);
        drive(1, 2'd3, 0, 1, 1);
        chk("clr_valid", 32'(y_valid), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);
`ifdef LP_DEC_ACCUM_EN
        chk("clr_acc", 32'(acc), 32'd0);
`endif

        // Accumulator: deliver 0 and 2, then 2 again.
        drive(1, 2'd0, 0, 1, 0);
        drive(1, 2'd2, 0, 1, 0);
        drive(0, 2'd0, 0, 1, 0);
`ifdef LP_DEC_ACCUM_EN
        chk("acc_0101", 32'(acc), 32'h5);
`endif
        drive(1, 2'd2, 0, 1, 0);
        drive(0, 2'd0, 0, 1, 0);
`ifdef LP_DEC_ACCUM_EN
        chk("acc_stay", 32'(acc), 32'h5);
`endif

        // Asynchronous reset with three entries queued.
        drive(1, 2'd1, 0, 0, 0);
        drive(1, 2'd2, 0, 0, 0);
        drive(1, 2'd3, 0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(y_valid), 32'd0);
        chk("arst_y", 32'(y), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
`ifdef LP_DEC_ACCUM_EN
        chk("arst_acc", 32'(acc), 32'd0);
`endif
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_valid", 32'(y_valid), 32'd0);
        drive(1, 2'd1, 0, 0, 0);
        chk("resume_y", 32'(y), 32'h2);
        drive(0, 2'd0, 0, 1, 0);

        // Random traffic checked by the every-cycle compare.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 5 == 0),
                  1'($urandom % 3 != 0), 1'($urandom % 25 == 0));
        end
        drive(0, 2'd0, 0, 1, 0);

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lp_decode_seq

`default_nettype wire

// File: doc/lp_decode_seq.md
LP_DECODE_SEQ -- requirements
Module: lp_decode_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clr  input  1  synchronous flush of FIFO and accumulator.
REQ-005 SHALL have port in_valid  input  1  code present.
REQ-006 SHALL have port in_code  input  2  bit index from low-priority encoder.
REQ-007 SHALL have port in_none  input  1  encoder saw no set bit; decodes to 4'b0000.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept this cycle.
REQ-009 SHALL have port y  output  4  one-hot decode of FIFO head.
REQ-010 SHALL have port y_valid  output  1  y holds a valid decode.
REQ-011 SHALL have port y_ready  input  1  consumer takes y this cycle.
REQ-012 SHALL have port acc  output  4  OR of all delivered decodes (present only with LP_DEC_ACCUM_EN).

Function
REQ-013 SHALL store {in_none, in_code} (3 bits) per entry in a DEPTH-entry show-ahead FIFO.
REQ-014 SHALL push on clock edge when in_valid && in_ready && !clr.
REQ-015 SHALL drive in_ready = (count != DEPTH); a pop in the same cycle does not raise in_ready when full.
REQ-016 SHALL drive y_valid = (count != 0), combinationally from state registers only.
REQ-017 SHALL drive y = 4'b0000 when head in_none=1, else 4'b0001 << head in_code; y = 4'b0000 when y_valid=0.
REQ-018 SHALL pop on clock edge when y_valid && y_ready && !clr.
REQ-019 SHALL give latency one cycle: code pushed at edge N into empty FIFO appears on y/y_valid after edge N.
REQ-020 SHALL keep y stable while y_valid && !y_ready.
REQ-021 SHALL handle simultaneous push and pop (count 1..DEPTH-1) with count unchanged, order preserved.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.
REQ-023 SHALL on clr set count, pointers and acc to 0 in that edge; clr beats concurrent push/pop.
REQ-024 SHALL ignore in_code/in_none when in_valid=0 or not accepted.

Reset
REQ-025 SHALL on rst_n=0 immediately force count=0, pointers=0, acc=0, hence y_valid=0, y=0, in_ready=1.
REQ-026 SHALL discard all queued entries on reset mid-operation; no partial delivery after release.
REQ-027 SHALL resume accepting on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL compile the accumulator and acc port only when LP_DEC_ACCUM_EN is defined.
REQ-029 SHALL, with LP_DEC_ACCUM_EN, update acc <= acc | y on each pop edge; in_none pops leave acc unchanged.
REQ-030 SHALL, without LP_DEC_ACCUM_EN, omit acc port and register; all other behaviour identical.

Structure
REQ-031 SHALL place the entry width (3), code width (2), output width (4) and the one-hot decode function in shared package lp_pkg.
REQ-032 SHALL implement FIFO storage/pointers as sub-module lp_code_fifo; decode and accumulator stay in lp_decode_seq.

Verification
REQ-033 SHALL test reset: rst_n=0 mid-stream with 3 entries queued -> y_valid=0, y=0000, in_ready=1, acc=0000 without clock edge.
REQ-034 SHALL test decode sweep: push codes 0,1,2,3 with y_ready=1 -> y = 0001, 0010, 0100, 1000 on successive cycles, one cycle after each push.
REQ-035 SHALL test in_none: push in_none=1, in_code=2'b11 -> y_valid=1, y=0000; acc unchanged.
REQ-036 SHALL test full/backpressure: y_ready=0, push 4 codes (DEPTH=4) -> in_ready=0; 5th push dropped; then y_ready=1 drains exactly 4 in order.
REQ-037 SHALL test clr with concurrent push and pop at count=2 -> next cycle count=0, y_valid=0, acc=0000.
REQ-038 SHALL test accumulator (LP_DEC_ACCUM_EN): deliver codes 0 and 2 -> acc=0101; deliver code 2 again -> acc stays 0101.
